// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch requester (I) and the
// load/store requester (D). The winning request is registered onto the master
// port; the source of every granted request is pushed into a small tag FIFO so
// that the in-order memory responses are steered back to the right requester.
//
// Parameters:
//   ADDR_W    address width
//   DATA_W    data width
//   MAX_OUTS  maximum outstanding requests (power of 2, >= 2)
//
// Build option:
//   MEM_ARB_DPRIO_EN  when defined, D always wins a tie (fixed priority);
//                     otherwise ties are resolved round-robin, D first.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req_valid/ready/addr        fetch request channel
//   i_rsp_valid/ready/data        fetch response channel
//   d_req_valid/ready/addr/we/wdata  LSU request channel
//   d_rsp_valid/ready/data        LSU response channel (load data or store ack)
//   m_req_valid/ready/addr/we/wdata  registered memory request channel
//   m_rsp_valid/ready/data        memory response channel, in request order
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,

    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic              m_req_we,
    output logic [DATA_W-1:0] m_req_wdata,
    input  logic              m_rsp_valid,
    output logic              m_rsp_ready,
    input  logic [DATA_W-1:0] m_rsp_data
);

    localparam int PTR_W = $clog2(MAX_OUTS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

    // Master request register
    logic              m_req_valid_q, m_req_valid_d;
    logic [ADDR_W-1:0] m_req_addr_q,  m_req_addr_d;
    logic              m_req_we_q,    m_req_we_d;
    logic [DATA_W-1:0] m_req_wdata_q, m_req_wdata_d;

    // Tag FIFO: one bit per outstanding request, 0 = I, 1 = D
    logic [MAX_OUTS-1:0] tag_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;

    logic empty;
    logic head_is_d;
    logic pop;
    logic cke;
    logic room;
    logic eligible;
    logic tie_pick_d;
    logic sel_d;
    logic push;

`ifndef MEM_ARB_DPRIO_EN
    // Source of the most recent grant, 0 = I, 1 = D
    logic last_grant_q;
`endif

    // -----------------------------------------------------------------------
    // Response routing
    // -----------------------------------------------------------------------
    always_comb begin
        empty       = (count_q == '0);
        head_is_d   = tag_q[rd_ptr_q];
        i_rsp_valid = m_rsp_valid & ~empty & ~head_is_d;
        d_rsp_valid = m_rsp_valid & ~empty &  head_is_d;
        i_rsp_data  = m_rsp_data;
        d_rsp_data  = m_rsp_data;
        // A beat with nothing outstanding is accepted and thrown away so a
        // misbehaving memory cannot wedge the port.
        m_rsp_ready = empty | (head_is_d ? d_rsp_ready : i_rsp_ready);
        pop         = m_rsp_valid & m_rsp_ready & ~empty;
    end

    // -----------------------------------------------------------------------
    // Grant
    // -----------------------------------------------------------------------
`ifdef MEM_ARB_DPRIO_EN
    assign tie_pick_d = 1'b1;
`else
    assign tie_pick_d = ~last_grant_q;
`endif

    always_comb begin
        cke = ~m_req_valid_q | m_req_ready;
        // A response retired this cycle frees a slot for a grant this cycle,
        // so a full port keeps streaming at one request per cycle.
        room     = (count_q < CNT_MAX) | pop;
        eligible = cke & room;
        sel_d    = d_req_valid & (~i_req_valid | tie_pick_d);
        push     = eligible & (i_req_valid | d_req_valid);
        i_req_ready = eligible & ~sel_d;
        d_req_ready = eligible &  sel_d;
    end

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        m_req_valid_d = m_req_valid_q;
        m_req_addr_d  = m_req_addr_q;
        m_req_we_d    = m_req_we_q;
        m_req_wdata_d = m_req_wdata_q;
        if (cke) begin
            m_req_valid_d = push;
            if (push) begin
                if (sel_d) begin
                    m_req_addr_d  = d_req_addr;
                    m_req_we_d    = d_req_we;
                    m_req_wdata_d = d_req_wdata;
                end else begin
                    m_req_addr_d  = i_req_addr;
                    m_req_we_d    = 1'b0;
                    m_req_wdata_d = '0;
                end
            end
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_valid_q <= 1'b0;
            m_req_addr_q  <= '0;
            m_req_we_q    <= 1'b0;
            m_req_wdata_q <= '0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            m_req_valid_q <= m_req_valid_d;
            m_req_addr_q  <= m_req_addr_d;
            m_req_we_q    <= m_req_we_d;
            m_req_wdata_q <= m_req_wdata_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            // When full, the slot written here is the one being popped this
            // cycle; its old value has already been used for routing.
            if (push) begin
                tag_q[wr_ptr_q] <= sel_d;
            end
        end
    end

`ifndef MEM_ARB_DPRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if (push) begin
            last_grant_q <= sel_d;
        end
    end
`endif

    assign m_req_valid = m_req_valid_q;
    assign m_req_addr  = m_req_addr_q;
    assign m_req_we    = m_req_we_q;
    assign m_req_wdata = m_req_wdata_q;

endmodule
